// File: rtl/ctr_sched_pkg.sv
// Shared defaults and types for the round-robin counter scheduler.
package ctr_sched_pkg;
    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 3;

    typedef logic [CNT_W_DEF-1:0]          cnt_t;
    typedef logic [$clog2(NUM_CH_DEF)-1:0] ptr_t;
endpackage

// File: rtl/ctr_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first effective request at or after ptr.
// Owns the rotating priority pointer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] ereq,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] next_ptr;
    logic [PW:0]   sum;
    logic [PW:0]   inc;
    logic          found;

    // Walk the channels in priority order ptr, ptr+1, ... modulo N.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N))
                sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!found && ereq[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found && rst_n)
            gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        inc = {1'b0, gnt_idx} + (PW+1)'(1);
        if (inc >= (PW+1)'(N))
            next_ptr = '0;
        else
            next_ptr = inc[PW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance)
            ptr <= next_ptr;
    end
endmodule

// File: rtl/ctr_sched.sv
// Shares one count-increment path among NUM_CH channels via round-robin grants,
// with per-channel clear and a one-cycle wrap pulse.
module ctr_sched
    import ctr_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH-1:0]       gnt,
    output logic [NUM_CH*CNT_W-1:0] cnt,
    output logic [NUM_CH-1:0]       wrap,
    output logic                    busy
);
    logic [NUM_CH-1:0] ereq;
    logic [NUM_CH-1:0] xfer;

    assign ereq = req & ~clr;
    assign busy = |ereq;
    assign xfer = req & gnt;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .ereq    (ereq),
        .advance (|xfer),
        .gnt     (gnt)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] count;
        logic             wrap_q;

        // Clear wins over a same-cycle increment and suppresses the wrap pulse.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                count  <= '0;
                wrap_q <= 1'b0;
            end else begin
                wrap_q <= 1'b0;
                if (clr[i]) begin
                    count <= '0;
                end else if (xfer[i]) begin
                    count  <= count + CNT_W'(1);
                    wrap_q <= &count;
                end
            end
        end

        assign cnt[i*CNT_W +: CNT_W] = count;
        assign wrap[i]               = wrap_q;
    end
endmodule

// File: tb/tb_ctr_sched.sv
// Self-checking bench for ctr_sched: table vectors, directed corner sequences
// and randomized traffic against a behavioural model.
module tb_ctr_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  clr;
    logic [3:0]  gnt;
    logic [11:0] cnt;
    logic [3:0]  wrap;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    int          m_cnt[4];
    int          m_ptr;
    logic [3:0]  m_wrap;
    logic [3:0]  last_gnt;

    always #5 clk = ~clk;

    ctr_sched #(.NUM_CH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .clr   (clr),
        .gnt   (gnt),
        .cnt   (cnt),
        .wrap  (wrap),
        .busy  (busy)
    );

    typedef struct {
        logic        r;
        logic [3:0]  rq;
        logic [3:0]  cl;
        logic [3:0]  gnt;
        logic [11:0] cnt;
        logic [3:0]  wrap;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_gnt(input logic r, input logic [3:0] rq, input logic [3:0] cl);
        logic [3:0] e;
        int         ch;
        e = rq & ~cl;
        if (!r) return 4'b0;
        for (int off = 0; off < 4; off++) begin
            ch = (m_ptr + off) % 4;
            if (e[ch]) return 4'(1 << ch);
        end
        return 4'b0;
    endfunction

    task automatic model_update(input logic r, input logic [3:0] rq, input logic [3:0] cl, input logic [3:0] g);
        if (!r) begin
            for (int ch = 0; ch < 4; ch++) m_cnt[ch] = 0;
            m_wrap = 4'b0;
            m_ptr  = 0;
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                m_wrap[ch] = 1'b0;
                if (cl[ch]) begin
                    m_cnt[ch] = 0;
                end else if (g[ch] && rq[ch]) begin
                    m_wrap[ch] = (m_cnt[ch] == 7);
                    m_cnt[ch]  = (m_cnt[ch] + 1) % 8;
                end
            end
            for (int ch = 0; ch < 4; ch++)
                if (g[ch]) m_ptr = (ch + 1) % 4;
        end
    endtask

    // One clock of stimulus: check combinational outputs mid-cycle, then state after the edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] cl);
        logic [3:0] eg;
        rst_n = r;
        req   = rq;
        clr   = cl;
        #3;
        eg       = model_gnt(r, rq, cl);
        last_gnt = gnt;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(|(rq & ~cl)));
        @(posedge clk);
        #1;
        model_update(r, rq, cl, eg);
        for (int ch = 0; ch < 4; ch++) begin
            chk("cnt", 32'(cnt[ch*3 +: 3]), 32'(m_cnt[ch]));
            chk("wrap", 32'(wrap[ch]), 32'(m_wrap[ch]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        clr   = '0;
        m_ptr = 0;
        m_wrap = '0;
        for (int ch = 0; ch < 4; ch++) m_cnt[ch] = 0;

        // Reset with all requesting, then eight round-robin cycles.
        tbl[0] = '{1'b0, 4'hF, 4'h0, 4'b0000, 12'h000, 4'h0};
        tbl[1] = '{1'b0, 4'hF, 4'h0, 4'b0000, 12'h000, 4'h0};
        tbl[2] = '{1'b1, 4'hF, 4'h0, 4'b0001, 12'h001, 4'h0};
        tbl[3] = '{1'b1, 4'hF, 4'h0, 4'b0010, 12'h009, 4'h0};
        tbl[4] = '{1'b1, 4'hF, 4'h0, 4'b0100, 12'h049, 4'h0};
        tbl[5] = '{1'b1, 4'hF, 4'h0, 4'b1000, 12'h249, 4'h0};
        tbl[6] = '{1'b1, 4'hF, 4'h0, 4'b0001, 12'h24A, 4'h0};
        tbl[7] = '{1'b1, 4'hF, 4'h0, 4'b0010, 12'h252, 4'h0};
        tbl[8] = '{1'b1, 4'hF, 4'h0, 4'b0100, 12'h292, 4'h0};
        tbl[9] = '{1'b1, 4'hF, 4'h0, 4'b1000, 12'h492, 4'h0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].rq, tbl[i].cl);
            chk("tbl_gnt", 32'(last_gnt), 32'(tbl[i].gnt));
            chk("tbl_cnt", 32'(cnt), 32'(tbl[i].cnt));
            chk("tbl_wrap", 32'(wrap), 32'(tbl[i].wrap));
        end

        // Single channel wrap on ch2.
        step(1'b0, 4'h0, 4'h0);
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 4'b0100, 4'h0);
            chk("sw_gnt", 32'(last_gnt), 32'h4);
            chk("sw_cnt2", 32'(cnt[8:6]), 32'((k + 1) % 8));
            chk("sw_wrap", 32'(wrap), (k == 7) ? 32'h4 : 32'h0);
        end

        // Pointer rotation after a ch1 grant.
        step(1'b0, 4'h0, 4'h0);
        step(1'b1, 4'b0010, 4'h0);
        step(1'b1, 4'b0011, 4'h0);
        chk("rot_gnt0", 32'(last_gnt), 32'h1);
        step(1'b1, 4'b0011, 4'h0);
        chk("rot_gnt1", 32'(last_gnt), 32'h2);

        // Clear beats increment and does not move ptr.
        step(1'b0, 4'h0, 4'h0);
        for (int k = 0; k < 5; k++) step(1'b1, 4'b1000, 4'h0);
        chk("clr_pre3", 32'(cnt[11:9]), 32'd5);
        step(1'b1, 4'b1001, 4'b1000);
        chk("clr_gnt", 32'(last_gnt), 32'h1);
        chk("clr_cnt3", 32'(cnt[11:9]), 32'd0);
        chk("clr_cnt0", 32'(cnt[2:0]), 32'd1);
        chk("clr_wrap", 32'(wrap), 32'h0);
        step(1'b1, 4'hF, 4'h0);
        chk("clr_ptr", 32'(last_gnt), 32'h2);

        // Reset mid-operation with ch3 at max and requesting.
        step(1'b0, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 4'b0001, 4'h0);
        for (int k = 0; k < 6; k++) step(1'b1, 4'b0010, 4'h0);
        step(1'b1, 4'b0100, 4'h0);
        for (int k = 0; k < 7; k++) step(1'b1, 4'b1000, 4'h0);
        chk("mid_pre", 32'(cnt), 32'({3'd7, 3'd1, 3'd6, 3'd3}));
        step(1'b0, 4'hF, 4'h0);
        chk("mid_gnt", 32'(last_gnt), 32'h0);
        chk("mid_cnt", 32'(cnt), 32'h0);
        chk("mid_wrap", 32'(wrap), 32'h0);
        step(1'b1, 4'hF, 4'h0);
        chk("mid_first", 32'(last_gnt), 32'h1);

        // Randomized traffic with sparse clears and occasional resets.
        for (int k = 0; k < 400; k++) begin
            logic       r;
            logic [3:0] rq;
            logic [3:0] cl;
            r  = ($urandom_range(0, 49) != 0);
            rq = 4'($urandom);
            cl = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            step(r, rq, cl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ctr_sched.md
# ctr_sched

Round-robin scheduler that shares one 3-bit up-counter increment datapath among several requesters. Each channel owns a stored count. The block grants at most one channel per cycle, increments that channel's count with wrap-around, and flags the wrap. It sits between independent event sources and the shared counter resource, replacing per-source free-running counters.

## Interface
Parameters:
- NUM_CH, 4: number of requesting channels (2..8)
- CNT_W, 3: width of each channel count

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous and active-low
- req  input  NUM_CH  per-channel increment request, level; one increment per cycle in which req[i] && gnt[i]
- clr  input  NUM_CH  per-channel synchronous count clear
- gnt  output  NUM_CH  one-hot or zero grant; combinational from req, clr and the registered pointer
- cnt  output  NUM_CH*CNT_W  flattened registered counts; channel i at bits [i*CNT_W +: CNT_W]
- wrap  output  NUM_CH  registered one-cycle pulse when channel count goes from max to 0 through an increment
- busy  output  1  combinational; high when any effective request is pending (req & ~clr)

## Operation
- Effective request: ereq = req & ~clr. A channel being cleared is excluded from arbitration that cycle.
- Arbitration: a registered pointer ptr (log2 NUM_CH bits) names the highest-priority channel. Search order is ptr, ptr+1, … modulo NUM_CH. gnt is the first set bit of ereq in that order; gnt is 0 if ereq is 0.
- Transfer: occurs when req[i] && gnt[i]. On the next edge cnt[i] <= cnt[i]+1, modulo 2^CNT_W (7 -> 0 for CNT_W=3). ptr <= (i+1) mod NUM_CH.
- No grant: ptr holds.
- wrap[i]: set for exactly the cycle after a transfer on channel i whose pre-increment count was all-ones. It is 0 otherwise, including after clr.
- clr[i]: cnt[i] <= 0 on the next edge. clr overrides any increment and does not move ptr. Multiple clr bits may be asserted simultaneously.
- Non-granted channels' counts hold.
- Fairness: with all channels requesting continuously, any channel waits at most NUM_CH-1 cycles between grants.
- Reset (rst_n low at an edge): all cnt = 0, wrap = 0, ptr = 0. While rst_n is low, gnt is forced to 0 and no transfer occurs. Reset asserted mid-operation discards any in-flight request. The first grant after release goes to the lowest-index requester.

## Timing
- Request to grant: 0 cycles (same cycle, combinational).
- Grant to cnt update: 1 edge.
- Transfer to wrap pulse: 1 edge, coincident with cnt becoming 0.
- Throughput: one increment per cycle total across all channels.
- No combinational path from any output back to req/clr.
- busy and gnt are valid only after inputs settle. Requesters must not derive req combinationally from gnt.

## Structure
- Shared package ctr_sched_pkg holds:
  - NUM_CH_DEF = 4 and CNT_W_DEF = 3
  - typedef cnt_t (logic [CNT_W-1:0])
  - typedef ptr_t
- Sub-module rr_arbiter (params N): inputs clk, rst_n, ereq, advance; outputs one-hot gnt. It owns ptr.
- The top level holds the count registers, clear/increment mux and wrap registers.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=4'hF -> gnt=0 throughout, all cnt=0, wrap=0. After release, first gnt=4'b0001.
- Single channel wrap: req=4'b0100 held 9 cycles from reset -> gnt=4'b0100 every cycle. cnt2 steps 1..7,0,1. wrap[2] is high only in the cycle cnt2 becomes 0.
- Round-robin: req=4'hF for 8 cycles from reset -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000. Each count ends at 2.
- Pointer rotation: after a grant to ch1, apply req=4'b0011 -> gnt=4'b0001 (search order 2,3,0,1). The next cycle gives gnt=4'b0010.
- Clear priority: cnt3=5, req=4'b1001, clr=4'b1000 -> gnt=4'b0001. Next cycle cnt3=0, cnt0 incremented, no wrap, ptr=1.
- Reset mid-operation: counts {3,6,1,7} with req=4'hF, then rst_n=0 for one edge -> all cnt=0, wrap=0 (no wrap on ch3). After release, gnt=4'b0001.
